// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequences the PC, reads a combinational word-addressed ROM
// and buffers {pc, instr} pairs in a DEPTH-entry queue for the decode stage.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          IM_AW    = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [IM_AW-1:0]           imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pcp4,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic push;
  logic pop;

  // Handshake: the head transfers on any edge where out_valid and out_ready are both
  // high; out_valid never depends on out_ready, and a redirect in that cycle kills it.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~redirect & ((count < DEPTH_C) | pop);

  assign imem_addr = pc[IM_AW+1:2];
  assign occupancy = count;

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    out_pcp4  = '0;
    if (out_valid) begin
      out_instr = q_instr[rd_ptr];
      out_pc    = q_pc[rd_ptr];
      out_pcp4  = q_pc[rd_ptr] + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
